r_format_exec_unit: RTL and testbench
=====================================

# r_format_exec_unit

Parametrised R-format execute/write-back unit: an internal register file, an ALU and a four-state sequencer that reads two source registers, executes `dest = rs op rt` and writes the result back. It extends the single-register write stage to a full register file with a start/done handshake, flags, a preload port and a debug read port. It sits between instruction decode (which supplies fields and `start`) and the rest of the datapath (which consumes `out_data` and the flags).

## Interface
Parameters:
- `WIDTH`, 32, data width of registers, ALU and `out_data`.
- `ADDR_W`, 5, register address width; the file holds 2**ADDR_W registers.
- `ZERO_REG`, 1, when 1 register 0 always reads 0 and ignores writes; when 0 it is an ordinary register.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset_input` in 1: asynchronous, active-high reset.
- `start` in 1: request one operation; sampled only in IDLE.
- `ALU_operation` in 3: opcode (see Operation).
- `rs_address`, `rt_address`, `out_address` in ADDR_W each: source 1, source 2 and destination register.
- `write_enabled` in 1: write the result to `out_address` at the end of the operation.
- `load_en` in 1, `load_address` in ADDR_W, `load_data` in WIDTH: direct register preload; honoured only in IDLE.
- `dbg_address` in ADDR_W, `dbg_data` out WIDTH: combinational read of any register.
- `busy` out 1: an operation is in flight.
- `done` out 1: one-cycle pulse when the write-back completes.
- `out_data` out WIDTH: result of the last completed operation, held until the next completion.
- `zero`, `overflow`, `illegal_op` out 1 each: flags of the last completed operation, held with `out_data`.

## Operation
- States: IDLE -> READ -> EXEC -> WRITE -> IDLE. No other transitions.
- IDLE: when `start`=1, latch `ALU_operation`, all three addresses and `write_enabled`, then go to READ. If `start`=0, stay in IDLE.
- READ: latch the operand values from the latched rs/rt addresses, then go to EXEC.
- EXEC: compute the result and flags into internal registers, then go to WRITE.
- WRITE: update `out_data` and the flags, pulse `done`, and write the register file when all of these hold: latched `write_enabled`=1, the opcode is legal, and the destination is not (ZERO_REG and address 0). Then go to IDLE.
- Opcodes:
  - 000 AND, 001 OR.
  - 010 ADD, 110 SUB: wrap modulo 2**WIDTH.
  - 111 SLT: signed compare; result is 1 or 0, zero-extended.
  - All other codes are illegal: result 0, `illegal_op`=1, no write.
- `overflow`: signed overflow for ADD/SUB only, 0 for all other opcodes.
- `zero`: 1 when the result equals 0, including for illegal opcodes.
- `start` and `load_en` are ignored outside IDLE.
- `load_en` and `start` in the same IDLE cycle: both are accepted. The load lands at that edge, so the following READ sees the loaded value.
- `dbg_data` reflects the file contents after the most recent edge. With ZERO_REG=1, address 0 returns 0.

## Timing
- Reset values: all registers 0, state IDLE, `out_data`=0, `zero`=`overflow`=`illegal_op`=0, `busy`=0, `done`=0.
- Reset asserted in any state aborts the operation immediately; no register-file write occurs.
- For `start` sampled at edge k:
  - `busy`=1 after edges k, k+1 and k+2.
  - After edge k+3: `busy`=0, `done`=1 for exactly one cycle, `out_data`/flags updated, destination register written.
- `start` held high during the `done` cycle is accepted (state is IDLE), giving back-to-back operations every 4 cycles.
- Inputs other than `start`/load may change freely after edge k; only latched values are used.
- A destination equal to a source register: the write at edge k+3 does not affect the current operation's operands, which were read at edge k+1.

## Test plan
- Load r1=5 and r2=7, then ADD (010), rs=1, rt=2, out=5, we=1 -> at edge k+3 `done`=1, `out_data`=12, `dbg_data`(5)=12, `zero`=0.
- Load r1=0x80000000 and r2=1, then SUB -> `out_data`=0x7FFFFFFF, `overflow`=1. ADD 0xFFFFFFFF+1 -> `out_data`=0, `zero`=1, `overflow`=0.
- SLT with r3=0xFFFFFFFF (-1) and r4=1 -> `out_data`=1. Swapped operands -> `out_data`=0.
- ADD with out=0 (ZERO_REG=1) -> `out_data` shows the sum, `dbg_data`(0)=0. Operation with we=0 -> `out_data` updated, file unchanged. Opcode 011 -> `illegal_op`=1, `out_data`=0, no write.
- `start` pulsed while `busy` -> ignored, exactly one `done`. `start` held continuously -> `done` every 4 cycles.
- Assert `reset_input` during EXEC of an ADD to r5 -> outputs 0 immediately, r5 reads 0, no `done` pulse, state IDLE after release.

Source files
------------

// File: rtl/r_format_exec_unit.sv
// r_format_exec_unit
// ------------------
// R-format execute/write-back unit. It holds a register file, an ALU and a
// four-state sequencer. Each operation runs IDLE -> READ -> EXEC -> WRITE.
// It reads two source registers, computes dest = rs op rt and optionally
// writes the result back.
//
// Handshake: `start` is sampled only while the sequencer is IDLE (`busy`=0).
// A start accepted at edge k produces a one-cycle `done` pulse after edge k+3.
// At the same time `out_data` and the flags update, and the destination
// register is written. A start held high during the `done` cycle is accepted
// again, so the unit issues back to back every 4 cycles. The preload port
// (`load_en`) is honoured only in IDLE. A preload that coincides with an
// accepted start lands before the operands are read.
//
// Ports:
//   clk, reset_input       clock, asynchronous active-high reset
//   start                  request one operation (IDLE only)
//   ALU_operation[2:0]     opcode: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//   rs/rt/out_address      source 1, source 2, destination register
//   write_enabled          write the result back at the end of the operation
//   load_en/address/data   direct register preload (IDLE only)
//   dbg_address/dbg_data   combinational register read
//   busy, done             operation in flight / write-back completion pulse
//   out_data, zero, overflow, illegal_op   result and flags of last completion
//   dbg_state[1:0]         sequencer state (0 IDLE, 1 READ, 2 EXEC, 3 WRITE)
module r_format_exec_unit #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset_input,
  input  logic              start,
  input  logic [2:0]        ALU_operation,
  input  logic [ADDR_W-1:0] rs_address,
  input  logic [ADDR_W-1:0] rt_address,
  input  logic [ADDR_W-1:0] out_address,
  input  logic              write_enabled,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_address,
  input  logic [WIDTH-1:0]  load_data,
  input  logic [ADDR_W-1:0] dbg_address,
  output logic [WIDTH-1:0]  dbg_data,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  out_data,
  output logic              zero,
  output logic              overflow,
  output logic              illegal_op,
  output logic [1:0]        dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  state_t state, state_next;

  logic [WIDTH-1:0] regs [DEPTH];

  // Fields latched at acceptance; later input changes are ignored.
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rs_q, rt_q, out_q;
  logic              we_q;

  logic [WIDTH-1:0]  a_q, b_q;
  logic [WIDTH-1:0]  res_q;
  logic              zero_q, ovf_q, ill_q;

  // Control decoded from state.
  logic accept, load_ok, do_read, do_exec, do_write, wb_en;

  logic [WIDTH-1:0] rs_val, rt_val;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf, alu_ill;
  logic [WIDTH-1:0] sum, diff;
  logic             slt_bit;

  // ---------------------------------------------------------------------
  // Sequencer: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset_input) begin
    if (reset_input) state <= S_IDLE;
    else             state <= state_next;
  end

  // Sequencer: next state
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_READ;
      S_READ:  state_next = S_EXEC;
      S_EXEC:  state_next = S_WRITE;
      S_WRITE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Sequencer: outputs
  always_comb begin
    busy      = (state != S_IDLE);
    dbg_state = state;
    accept    = (state == S_IDLE) && start;
    do_read   = (state == S_READ);
    do_exec   = (state == S_EXEC);
    do_write  = (state == S_WRITE);
    // Register 0 is hard-wired when ZERO_REG is set, so writes to it are dropped.
    load_ok   = (state == S_IDLE) && load_en &&
                !((ZERO_REG != 0) && (load_address == '0));
    wb_en     = do_write && we_q && !ill_q &&
                !((ZERO_REG != 0) && (out_q == '0));
  end

  // ---------------------------------------------------------------------
  // Register file reads
  // ---------------------------------------------------------------------
  always_comb begin
    rs_val   = ((ZERO_REG != 0) && (rs_q == '0))        ? '0 : regs[rs_q];
    rt_val   = ((ZERO_REG != 0) && (rt_q == '0))        ? '0 : regs[rt_q];
    dbg_data = ((ZERO_REG != 0) && (dbg_address == '0)) ? '0 : regs[dbg_address];
  end

  // ---------------------------------------------------------------------
  // ALU on the operands latched in READ
  // ---------------------------------------------------------------------
  always_comb begin
    sum     = a_q + b_q;
    diff    = a_q - b_q;
    slt_bit = ($signed(a_q) < $signed(b_q));
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (op_q)
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_ADD: begin
        alu_res = sum;
        // Like-signed operands producing a result of the other sign.
        alu_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        // Differently-signed operands where the result takes the sign of b.
        alu_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      default: alu_ill = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset_input) begin
    if (reset_input) begin
      op_q       <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      out_q      <= '0;
      we_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ill_q      <= 1'b0;
      out_data   <= '0;
      zero       <= 1'b0;
      overflow   <= 1'b0;
      illegal_op <= 1'b0;
      done       <= 1'b0;
    end else begin
      // `done` is high in the cycle after WRITE, when the state is IDLE again.
      done <= do_write;
      if (accept) begin
        op_q  <= ALU_operation;
        rs_q  <= rs_address;
        rt_q  <= rt_address;
        out_q <= out_address;
        we_q  <= write_enabled;
      end
      if (do_read) begin
        a_q <= rs_val;
        b_q <= rt_val;
      end
      if (do_exec) begin
        res_q  <= alu_res;
        zero_q <= (alu_res == '0);
        ovf_q  <= alu_ovf;
        ill_q  <= alu_ill;
      end
      if (do_write) begin
        out_data   <= res_q;
        zero       <= zero_q;
        overflow   <= ovf_q;
        illegal_op <= ill_q;
      end
    end
  end

  // Register file. Preload happens only in IDLE and write-back only in WRITE,
  // so the two ports never collide.
  always_ff @(posedge clk or posedge reset_input) begin
    if (reset_input) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (load_ok) regs[load_address] <= load_data;
      if (wb_en)   regs[out_q]        <= res_q;
    end
  end

endmodule

// File: tb/tb_r_format_exec_unit.sv
module tb_r_format_exec_unit;

  localparam int W = 32;
  localparam int A = 5;

  logic          clk = 1'b0;
  logic          reset_input;
  logic          start;
  logic [2:0]    ALU_operation;
  logic [A-1:0]  rs_address, rt_address, out_address;
  logic          write_enabled;
  logic          load_en;
  logic [A-1:0]  load_address;
  logic [W-1:0]  load_data;
  logic [A-1:0]  dbg_address;
  logic [W-1:0]  dbg_data;
  logic          busy, done;
  logic [W-1:0]  out_data;
  logic          zero, overflow, illegal_op;
  logic [1:0]    dbg_state;

  r_format_exec_unit #(.WIDTH(W), .ADDR_W(A), .ZERO_REG(1)) dut (
    .clk(clk), .reset_input(reset_input), .start(start),
    .ALU_operation(ALU_operation), .rs_address(rs_address),
    .rt_address(rt_address), .out_address(out_address),
    .write_enabled(write_enabled), .load_en(load_en),
    .load_address(load_address), .load_data(load_data),
    .dbg_address(dbg_address), .dbg_data(dbg_data), .busy(busy),
    .done(done), .out_data(out_data), .zero(zero), .overflow(overflow),
    .illegal_op(illegal_op), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Entry = {illegal_op, overflow, zero, out_data}
  logic [W+2:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int done_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'(done_count), 64'(0));
      end else begin
        logic [W+2:0] e;
        e = exp_q.pop_front();
        chk("result_flags", 64'({illegal_op, overflow, zero, out_data}), 64'(e));
      end
    end
  end

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic load_reg(input logic [A-1:0] a, input logic [W-1:0] d);
    load_en = 1'b1; load_address = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [A-1:0] a, input logic [W-1:0] exp);
    dbg_address = a;
    #1;
    chk(name, 64'(dbg_data), 64'(exp));
  endtask

  task automatic push_exp(input logic [W-1:0] d, input logic z, input logic o, input logic i);
    exp_q.push_back({i, o, z, d});
  endtask

  // Issue one op, wait for its done; returns at the negedge where done is high.
  task automatic run_op(input logic [2:0] op, input logic [A-1:0] rs, input logic [A-1:0] rt,
                        input logic [A-1:0] od, input logic we,
                        input logic [W-1:0] d, input logic z, input logic o, input logic i);
    int n;
    push_exp(d, z, o, i);
    start = 1'b1; ALU_operation = op; rs_address = rs; rt_address = rt;
    out_address = od; write_enabled = we;
    @(negedge clk);
    start = 1'b0; load_en = 1'b0;
    // Scramble fields: only latched values may be used.
    ALU_operation = 3'b101; rs_address = 5'd31; rt_address = 5'd30; out_address = 5'd29;
    write_enabled = ~we;
    n = 0;
    while (done !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("done_latency", 64'(n), 64'(3));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, got, cyc, last;
    reset_input = 1'b1; start = 1'b0; ALU_operation = '0;
    rs_address = '0; rt_address = '0; out_address = '0; write_enabled = 1'b0;
    load_en = 1'b0; load_address = '0; load_data = '0; dbg_address = '0;
    repeat (3) @(negedge clk);
    reset_input = 1'b0;
    @(negedge clk);

    chk("reset_busy",  64'(busy), 64'(0));
    chk("reset_done",  64'(done), 64'(0));
    chk("reset_out",   64'({illegal_op, overflow, zero, out_data}), 64'(0));
    chk("reset_state", 64'(dbg_state), 64'(0));
    check_reg("reset_r5", 5'd5, 32'h0);

    // ADD 5 + 7 -> r5
    load_reg(5'd1, 32'd5);
    load_reg(5'd2, 32'd7);
    run_op(3'b010, 5'd1, 5'd2, 5'd5, 1'b1, 32'd12, 1'b0, 1'b0, 1'b0);
    check_reg("add_r5", 5'd5, 32'd12);

    // SUB overflow: 0x80000000 - 1
    load_reg(5'd1, 32'h8000_0000);
    load_reg(5'd2, 32'h1);
    run_op(3'b110, 5'd1, 5'd2, 5'd6, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    check_reg("sub_r6", 5'd6, 32'h7FFF_FFFF);

    // ADD wrap to zero: 0xFFFFFFFF + 1, no signed overflow
    load_reg(5'd3, 32'hFFFF_FFFF);
    load_reg(5'd4, 32'h1);
    run_op(3'b010, 5'd3, 5'd4, 5'd7, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);

    // SLT signed: -1 < 1 -> 1 ; 1 < -1 -> 0
    run_op(3'b111, 5'd3, 5'd4, 5'd7, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
    check_reg("slt_r7", 5'd7, 32'h1);
    run_op(3'b111, 5'd4, 5'd3, 5'd7, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);

    // Write to r0 is dropped but out_data shows the sum
    run_op(3'b010, 5'd1, 5'd2, 5'd0, 1'b1, 32'h8000_0001, 1'b0, 1'b0, 1'b0);
    check_reg("zero_reg", 5'd0, 32'h0);

    // we=0: result visible, file unchanged
    run_op(3'b000, 5'd3, 5'd4, 5'd8, 1'b0, 32'h1, 1'b0, 1'b0, 1'b0);
    check_reg("no_we_r8", 5'd8, 32'h0);

    // Illegal opcode
    run_op(3'b011, 5'd3, 5'd4, 5'd9, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
    check_reg("illegal_r9", 5'd9, 32'h0);

    // OR
    run_op(3'b001, 5'd1, 5'd2, 5'd10, 1'b1, 32'h8000_0001, 1'b0, 1'b0, 1'b0);
    check_reg("or_r10", 5'd10, 32'h8000_0001);

    // Load and start in the same cycle: READ sees the loaded value
    load_en = 1'b1; load_address = 5'd11; load_data = 32'h55;
    run_op(3'b010, 5'd11, 5'd11, 5'd12, 1'b1, 32'hAA, 1'b0, 1'b0, 1'b0);
    check_reg("ld_start_r12", 5'd12, 32'hAA);

    // start pulsed while busy is ignored
    base = done_count;
    push_exp(32'h8000_0001, 1'b0, 1'b0, 1'b0);
    start = 1'b1; ALU_operation = 3'b010; rs_address = 5'd1; rt_address = 5'd2;
    out_address = 5'd15; write_enabled = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;   // sampled in READ
    @(negedge clk);                 // sampled in EXEC
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_start_ignored", 64'(done_count - base), 64'(1));

    // start held: back-to-back every 4 cycles, dest == source (r14 doubles)
    load_reg(5'd14, 32'd3);
    push_exp(32'd6,  1'b0, 1'b0, 1'b0);
    push_exp(32'd12, 1'b0, 1'b0, 1'b0);
    push_exp(32'd24, 1'b0, 1'b0, 1'b0);
    start = 1'b1; ALU_operation = 3'b010; rs_address = 5'd14; rt_address = 5'd14;
    out_address = 5'd14; write_enabled = 1'b1;
    got = 0; cyc = 0; last = 0;
    while (got < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        got++;
        if (got > 1) chk("b2b_gap", 64'(cyc - last), 64'(4));
        last = cyc;
        if (got == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("b2b_count", 64'(got), 64'(3));
    check_reg("b2b_r14", 5'd14, 32'd24);

    // Reset during EXEC aborts the op
    @(negedge clk);
    base = done_count;
    start = 1'b1; ALU_operation = 3'b010; rs_address = 5'd1; rt_address = 5'd2;
    out_address = 5'd5; write_enabled = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("pre_reset_exec", 64'(dbg_state), 64'(2));
    reset_input = 1'b1;
    #1;
    chk("rst_out", 64'({illegal_op, overflow, zero, out_data}), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    check_reg("rst_r5", 5'd5, 32'h0);
    @(negedge clk);
    reset_input = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_no_done", 64'(done_count - base), 64'(0));
    chk("rst_idle", 64'(dbg_state), 64'(0));
    check_reg("rst_r5_after", 5'd5, 32'h0);

    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
